// File: rtl/even_parity_rx.sv
// Serial receiver for start/data/even-parity/stop frames sampled on a bit-time strobe.
// Completion results (data, error flags, valid pulse) are registered one clk after the stop sample.
module even_parity_rx #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_bit_q, par_bit_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              busy_q, busy_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            par_bit_q <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            par_bit_q <= par_bit_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bit_en && !serial_in) state_d = DATA;
            DATA:    if (bit_en && (cnt_q == CNT_W'(DATA_W - 1))) state_d = PARITY;
            PARITY:  if (bit_en) state_d = STOP;
            STOP:    if (bit_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; nothing moves without a strobe
    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        par_bit_d = par_bit_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!serial_in) cnt_d = '0;
                end
                DATA: begin
                    for (int i = 0; i < int'(DATA_W); i++) begin
                        if (cnt_q == CNT_W'(i)) shift_d[i] = serial_in;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
                PARITY: begin
                    par_bit_d = serial_in;
                end
                STOP: begin
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    perr_d  = (^shift_q) ^ par_bit_q;
                    ferr_d  = ~serial_in;
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
        // Busy stretches through the completion cycle even though the FSM is already idle
        busy_d = (state_d != IDLE) || valid_d;
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_even_parity_rx.sv
// Self-checking bench for even_parity_rx: frame-level expectations from the driver,
// checked against the DUT every cycle, plus literal spot checks.
module tb_even_parity_rx;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bit_en = 1'b0;
    logic          serial_in = 1'b1;
    logic [DW-1:0] data_out;
    logic          valid, parity_err, frame_err, busy;

    logic [DW-1:0] exp_data = '0;
    logic          exp_valid = 1'b0, exp_perr = 1'b0, exp_ferr = 1'b0, exp_busy = 1'b0;
    bit            pending = 1'b0;

    int passed = 0;
    int total  = 0;

    even_parity_rx #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .serial_in(serial_in),
        .data_out(data_out), .valid(valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Compare every cycle, away from the rising edge
    always @(negedge clk) begin
        check1("valid",      16'(valid),      16'(exp_valid));
        check1("data_out",   16'(data_out),   16'(exp_data));
        check1("parity_err", 16'(parity_err), 16'(exp_perr));
        check1("frame_err",  16'(frame_err),  16'(exp_ferr));
        check1("busy",       16'(busy),       16'(exp_busy));
    end

    // One clk: drive inputs, let the edge sample them, then update frame-level expectations
    task automatic step(input logic be, input logic si, input bit is_start, input bit is_stop,
                        input logic [DW-1:0] d, input logic p);
        bit_en    = be;
        serial_in = si;
        @(posedge clk);
        #1;
        if (pending) begin
            exp_valid = 1'b0;
            exp_busy  = 1'b0;
            pending   = 1'b0;
        end
        if (is_start) exp_busy = 1'b1;
        if (is_stop) begin
            exp_valid = 1'b1;
            exp_data  = d;
            exp_perr  = (^d) ^ p;
            exp_ferr  = ~si;
            pending   = 1'b1;
        end
    endtask

    task automatic send_bit(input logic si, input int period, input bit is_start, input bit is_stop,
                            input logic [DW-1:0] d, input logic p);
        repeat (period - 1) step(1'b0, 1'($urandom), 1'b0, 1'b0, d, p);
        step(1'b1, si, is_start, is_stop, d, p);
    endtask

    task automatic do_reset();
        bit_en = 1'b0;
        #2;
        rst       = 1'b1;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
        exp_busy  = 1'b0;
        pending   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // abort_after < 0 sends the whole frame; otherwise reset hits after that many data bits
    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stop,
                              input int period, input int abort_after);
        send_bit(1'b0, period, 1'b1, 1'b0, d, p);
        for (int i = 0; i < int'(DW); i++) begin
            if (i == abort_after) begin
                do_reset();
                return;
            end
            send_bit(d[i], period, 1'b0, 1'b0, d, p);
        end
        send_bit(p, period, 1'b0, 1'b0, d, p);
        send_bit(stop, period, 1'b0, 1'b1, d, p);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'($urandom), 1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        send_frame(8'h00, 1'b0, 1'b1, 1, -1);
        check1("lit00_valid", 16'(valid), 16'h1);
        check1("lit00_data",  16'(data_out), 16'h00);
        check1("lit00_perr",  16'(parity_err), 16'h0);
        check1("lit00_ferr",  16'(frame_err), 16'h0);
        idle(2);

        send_frame(8'hDA, 1'b1, 1'b1, 1, -1);
        check1("litDA_data", 16'(data_out), 16'hDA);
        check1("litDA_perr", 16'(parity_err), 16'h0);
        send_frame(8'hDA, 1'b0, 1'b1, 1, -1);
        check1("litDA_bad_perr",  16'(parity_err), 16'h1);
        check1("litDA_bad_valid", 16'(valid), 16'h1);
        idle(2);

        send_frame(8'h03, 1'b0, 1'b0, 1, -1);
        check1("lit03_data", 16'(data_out), 16'h03);
        check1("lit03_ferr", 16'(frame_err), 16'h1);
        check1("lit03_perr", 16'(parity_err), 16'h0);
        idle(3);
        check1("lit03_idle_busy", 16'(busy), 16'h0);

        send_frame(8'hAA, 1'b0, 1'b1, 4, -1);
        check1("litAA_data", 16'(data_out), 16'hAA);
        check1("litAA_perr", 16'(parity_err), 16'h0);
        idle(1);
        check1("litAA_valid_width", 16'(valid), 16'h0);

        send_frame(8'hFF, 1'b0, 1'b1, 1, 4);
        check1("abort_valid", 16'(valid), 16'h0);
        idle(2);
        send_frame(8'h55, 1'b0, 1'b1, 1, -1);
        check1("lit55_data", 16'(data_out), 16'h55);
        check1("lit55_perr", 16'(parity_err), 16'h0);
        check1("lit55_ferr", 16'(frame_err), 16'h0);
        idle(2);

        send_frame(8'hFF, 1'b0, 1'b1, 1, -1);
        check1("b2b_first", 16'(data_out), 16'hFF);
        send_frame(8'h01, 1'b1, 1'b1, 1, -1);
        check1("b2b_second", 16'(data_out), 16'h01);
        check1("b2b_perr",   16'(parity_err), 16'h0);
        idle(2);

        // Low stop bit followed directly by a new start bit
        send_frame(8'h3C, 1'b0, 1'b0, 2, -1);
        send_frame(8'h81, 1'b0, 1'b1, 2, -1);
        check1("retrig_data", 16'(data_out), 16'h81);
        idle(2);

        for (int n = 0; n < 40; n++) begin
            logic [DW-1:0] d;
            logic          p;
            logic          stop;
            int            abort;
            d     = DW'($urandom);
            p     = ($urandom_range(3) == 0) ? 1'($urandom) : ^d;
            stop  = ($urandom_range(4) != 0);
            abort = ($urandom_range(9) == 0) ? int'($urandom_range(DW - 1)) : -1;
            send_frame(d, p, stop, int'($urandom_range(1, 4)), abort);
            idle(int'($urandom_range(3)));
        end
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/even_parity_rx.md
EVEN_PARITY_RX -- requirements
Module: even_parity_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the number of data bits per frame (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port bit_en, input, 1, bit-time strobe; serial_in is sampled only on clk edges where bit_en=1.
REQ-005 The block SHALL have port serial_in, input, 1, serial line; idles high.
REQ-006 The block SHALL have port data_out, output, DATA_W, the last received data word.
REQ-007 The block SHALL have port valid, output, 1, a one-clk pulse marking completion of a frame.
REQ-008 The block SHALL have port parity_err, output, 1, set when the last frame failed the even-parity check.
REQ-009 The block SHALL have port frame_err, output, 1, set when the last frame had a low stop bit.
REQ-010 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 Frame format SHALL be: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1), one bit per bit_en strobe.
REQ-012 The FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-013 IDLE: on bit_en with serial_in=0, go to DATA and clear the bit counter; serial_in=1 or bit_en=0 stays in IDLE.
REQ-014 DATA: each bit_en shifts serial_in into bit position count of the shift register and increments count; after DATA_W samples, go to PARITY.
REQ-015 PARITY: on bit_en, capture the parity bit and go to STOP.
REQ-016 STOP: on bit_en, go to IDLE and complete the frame per REQ-017 to REQ-019.
REQ-017 Frame completion SHALL occur in the clk cycle after the stop-bit sample; in that cycle valid=1 for exactly one cycle and data_out is loaded with the shift register.
REQ-018 parity_err SHALL be loaded with the XOR of all DATA_W data bits and the parity bit, so 1 means an odd total of ones.
REQ-019 frame_err SHALL be loaded with the inverse of the sampled stop bit.
REQ-020 data_out, parity_err and frame_err SHALL change only at frame completion and hold until the next completion.
REQ-021 A frame SHALL complete with valid=1 even if parity_err or frame_err is set; there is no silent discard.
REQ-022 Cycles with bit_en=0 SHALL leave the state, counter and shift register unchanged in every state.
REQ-023 After a frame_err, the block SHALL return to IDLE and need a fresh 0 sample to start; a low line re-triggers a start on the next bit_en.
REQ-024 The bit counter SHALL be $clog2(DATA_W)+1 bits wide and SHALL not wrap within a frame.
REQ-025 busy SHALL be high from the cycle after start detection until the cycle in which valid is asserted, inclusive of STOP.

Reset
REQ-026 When rst=1, the block SHALL force state=IDLE, counter=0, shift register=0, data_out=0, valid=0, parity_err=0, frame_err=0 and busy=0, independent of clk.
REQ-027 A reset asserted mid-frame SHALL abort the frame with no valid pulse; reception restarts at the next start bit after rst=0.

Verification
REQ-028 Send 0x00 with parity 0 and stop 1 (bit_en every clk) -> valid pulses once, data_out=0x00, parity_err=0, frame_err=0.
REQ-029 Send 0xDA with parity 1 (five ones plus parity gives an even total) -> data_out=0xDA, parity_err=0; resend 0xDA with parity 0 -> parity_err=1, valid=1.
REQ-030 Send 0x03 with parity 0 and stop bit 0 -> data_out=0x03, frame_err=1, parity_err=0, then the block returns to IDLE.
REQ-031 Send 0xAA with parity 0 and bit_en asserted only every 4th clk -> same result as continuous bit_en, valid width is 1 clk, and busy spans the frame.
REQ-032 Assert rst after 4 data bits of a 0xFF frame, then send 0x55 with parity 0 -> no valid before rst, then data_out=0x55 with no errors.
REQ-033 Run two back-to-back frames, 0xFF with parity 0 then 0x01 with parity 1, with the start bit right after the stop bit -> two valid pulses, data_out 0xFF then 0x01, no errors.
